stim_pattern_gen: RTL and testbench
===================================

Name: stim_pattern_gen

Overview:
Synthesizable, parametrised stimulus generator that replaces fixed hand-written clock/D delay sequences in flip-flop and register experiments. It plays a programmable table of (value, duration) steps on a DATA_W-bit data output. It also produces a divided test clock with a programmable half-period, so one block drives the CLK and D pins of any device under test. It supports single-shot and loop modes, stop, and a done indication.

Parameters:
DATA_W, 1, width of each step value and of d_out
DEPTH, 8, number of step-table entries (power of two, >=2)
DUR_W, 8, width of the per-step duration field, in clk cycles
DIV_W, 8, width of the test-clock half-period field

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
cfg_we  input  1  table write strobe
cfg_addr  input  $clog2(DEPTH)  table write address
cfg_value  input  DATA_W  value of the step being written
cfg_dur  input  DUR_W  duration of the step being written, in clk cycles
num_steps  input  $clog2(DEPTH)+1  number of steps to play; sampled on start
loop_en  input  1  1 = restart at step 0 after the last step; sampled on start
clk_div  input  DIV_W  test-clock half-period minus 1; sampled on start
start  input  1  begin playback (level-sampled, acts in IDLE only)
stop  input  1  abort playback
busy  output  1  1 while in RUN
done  output  1  one-cycle pulse when single-shot playback completes
step_idx  output  $clog2(DEPTH)  index of the step currently driven
d_out  output  DATA_W  generated data stimulus
tclk_out  output  1  generated test clock

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, step_idx=0, d_out=0, tclk_out=0; all table entries cleared to value 0, dur 0; latched config cleared.
- States: IDLE, RUN. No other states.
- Table write: when cfg_we=1 and state=IDLE, entry[cfg_addr] <= {cfg_value, cfg_dur} at the clk edge. cfg_we in RUN is ignored; the table is unchanged.
- Effective duration: eff_dur = (dur==0) ? 1 : dur. A step never lasts zero cycles.
- Start: in IDLE with start=1 and num_steps!=0:
  - latch N = min(num_steps, DEPTH), loop_en and clk_div;
  - at that same edge: state=RUN, busy=1, step_idx=0, d_out=entry[0].value, duration counter loaded with eff_dur[0].
  - start with num_steps=0 is ignored; the block stays in IDLE with no done.
  - start in RUN is ignored.
- Step timing: step i holds d_out for exactly eff_dur[i] clk cycles. On the edge its counter expires, step i+1 is loaded (value and counter) in the same edge, with no gap cycle. Total single-shot run = sum of eff_dur[0..N-1] cycles.
- End of step N-1:
  - loop_en=1: wrap to step 0 in the same edge; busy stays 1; no done.
  - loop_en=0: state=IDLE, busy=0, done=1 for exactly one cycle. d_out holds entry[N-1].value; step_idx holds N-1.
- Stop: stop=1 in RUN -> next edge state=IDLE, busy=0, no done. d_out and step_idx hold their current values. Stop has priority over step advance and over end-of-run in the same cycle. stop in IDLE has no effect.
- Test clock:
  - tclk_out=0 on entering RUN.
  - In RUN it toggles every (clk_div+1) clk cycles, giving period 2*(clk_div+1).
  - Its phase counter is independent of step boundaries and continues across loop wraps.
  - On leaving RUN (done or stop), tclk_out is forced to 0 at the same edge.
- Loop-mode playback runs until stop or rst.
- The latched N, loop_en and clk_div are not affected by input changes during RUN.
- All outputs are registered; no combinational path from any input to any output.

Test Plan:
- Reset mid-RUN: assert rst asynchronously during step 2 -> busy, done, d_out, tclk_out go 0 immediately, without a clk edge; a table read after reset shows all entries zero.
- Single shot, DATA_W=1: table (0,8),(1,9),(0,1),(1,4),(0,1),(1,10), N=6, loop_en=0, clk_div=4 ->
  - d_out = 0 x8, 1 x9, 0 x1, 1 x4, 0 x1, 1 x10 cycles;
  - done pulses once, 33 cycles after the start edge;
  - tclk_out period is 10 cycles during the run, then 0.
- Zero duration and clamping: entry[1].dur=0, num_steps=DEPTH+1 -> step 1 lasts exactly 1 cycle; exactly DEPTH steps are played.
- Loop mode: N=2, durations 3,5, loop_en=1 -> step_idx sequence 0,0,0,1,1,1,1,1,0,... with no done. Assert stop -> busy=0 next edge, no done, tclk_out=0.
- Ignored controls: cfg_we and start pulsed during RUN -> table and timing unchanged. start with num_steps=0 in IDLE -> busy stays 0.
- Simultaneous events: stop asserted on the final cycle of the last step with loop_en=0 -> IDLE with done=0.

Source files
------------

// File: rtl/stim_pattern_gen.sv
// stim_pattern_gen: plays a programmable table of (value, duration) steps on
// d_out and generates a divided test clock on tclk_out, so one block can drive
// both the D and CLK pins of a device under test.
//
// Ports:
//   clk, rst            system clock (rising edge), async active-high reset
//   cfg_we/addr/value/dur  step-table write port (accepted in IDLE only)
//   num_steps, loop_en, clk_div  playback configuration, latched on start
//   start, stop         begin playback (IDLE only) / abort playback (RUN only)
//   busy                high while playing
//   done                one-cycle pulse when single-shot playback completes
//   step_idx            index of the step currently driven
//   d_out               generated data stimulus
//   tclk_out            generated test clock, period 2*(clk_div+1)
module stim_pattern_gen #(
  parameter int unsigned DATA_W = 1,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DUR_W  = 8,
  parameter int unsigned DIV_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
  input  logic [DATA_W-1:0]          cfg_value,
  input  logic [DUR_W-1:0]           cfg_dur,
  input  logic [$clog2(DEPTH):0]     num_steps,
  input  logic                       loop_en,
  input  logic [DIV_W-1:0]           clk_div,
  input  logic                       start,
  input  logic                       stop,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH)-1:0]   step_idx,
  output logic [DATA_W-1:0]          d_out,
  output logic                       tclk_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NW = AW + 1;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic [AW-1:0]         idx_q;
  logic [DATA_W-1:0]     dout_q;
  logic                  tclk_q;
  logic [DUR_W-1:0]      cnt_q;
  logic [DIV_W-1:0]      ph_q;
  logic [AW-1:0]         last_q;
  logic                  loop_q;
  logic [DIV_W-1:0]      div_q;
  logic [DATA_W-1:0]     val_q [DEPTH];
  logic [DUR_W-1:0]      dur_q [DEPTH];

  logic [NW-1:0]         n_clamp_c;
  logic [AW-1:0]         last_c;
  logic [AW-1:0]         nxt_idx_c;

  // A zero duration still holds the step for one cycle.
  function automatic logic [DUR_W-1:0] eff_dur(input logic [DUR_W-1:0] d);
    return (d == '0) ? DUR_W'(1) : d;
  endfunction

  // Clamp requested step count to the table depth and derive the last index.
  always_comb begin
    n_clamp_c = (num_steps > NW'(DEPTH)) ? NW'(DEPTH) : num_steps;
    last_c    = AW'(n_clamp_c - NW'(1));
    nxt_idx_c = idx_q + AW'(1);
  end

  // Playback FSM, table storage and test-clock generation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      dout_q  <= '0;
      tclk_q  <= 1'b0;
      cnt_q   <= '0;
      ph_q    <= '0;
      last_q  <= '0;
      loop_q  <= 1'b0;
      div_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        val_q[i] <= '0;
        dur_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cfg_we) begin
            val_q[cfg_addr] <= cfg_value;
            dur_q[cfg_addr] <= cfg_dur;
          end
          if (start && (num_steps != '0)) begin
            last_q  <= last_c;
            loop_q  <= loop_en;
            div_q   <= clk_div;
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            idx_q   <= '0;
            dout_q  <= val_q[0];
            cnt_q   <= eff_dur(dur_q[0]);
            ph_q    <= '0;
            tclk_q  <= 1'b0;
          end
        end
        S_RUN: begin
          if (stop) begin
            // Abort wins over step advance and end-of-run; data and index hold.
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            tclk_q  <= 1'b0;
          end else begin
            // Test-clock phase runs free of step boundaries and loop wraps.
            if (ph_q == div_q) begin
              ph_q   <= '0;
              tclk_q <= ~tclk_q;
            end else begin
              ph_q <= ph_q + DIV_W'(1);
            end
            if (cnt_q != DUR_W'(1)) begin
              cnt_q <= cnt_q - DUR_W'(1);
            end else if (idx_q != last_q) begin
              idx_q  <= nxt_idx_c;
              dout_q <= val_q[nxt_idx_c];
              cnt_q  <= eff_dur(dur_q[nxt_idx_c]);
            end else if (loop_q) begin
              idx_q  <= '0;
              dout_q <= val_q[0];
              cnt_q  <= eff_dur(dur_q[0]);
            end else begin
              // Single-shot end: overrides the toggle above to park tclk low.
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              tclk_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          tclk_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign step_idx = idx_q;
  assign d_out    = dout_q;
  assign tclk_out = tclk_q;

endmodule

// File: tb/tb_stim_pattern_gen.sv
// Directed bench for stim_pattern_gen (DATA_W=1, DEPTH=8, DUR_W=8, DIV_W=8).
module tb_stim_pattern_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [0:0] cfg_value = '0;
  logic [7:0] cfg_dur = '0;
  logic [3:0] num_steps = '0;
  logic       loop_en = 1'b0;
  logic [7:0] clk_div = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       busy;
  logic       done;
  logic [2:0] step_idx;
  logic [0:0] d_out;
  logic       tclk_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Bench copy of what has been written into the table.
  int tv [8];
  int td [8];

  stim_pattern_gen #(.DATA_W(1), .DEPTH(8), .DUR_W(8), .DIV_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_value(cfg_value), .cfg_dur(cfg_dur), .num_steps(num_steps),
    .loop_en(loop_en), .clk_div(clk_div), .start(start), .stop(stop),
    .busy(busy), .done(done), .step_idx(step_idx), .d_out(d_out),
    .tclk_out(tclk_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input int v, input int d);
    cfg_we    = 1'b1;
    cfg_addr  = 3'(a);
    cfg_value = 1'(v);
    cfg_dur   = 8'(d);
    tick();
    cfg_we    = 1'b0;
    tv[a] = v;
    td[a] = d;
  endtask

  // Start a single-shot run and check every cycle against the bench table.
  task automatic play_check(input string tag, input int n, input int div);
    int nn, total, s, acc;
    nn = (n > 8) ? 8 : n;
    total = 0;
    for (int i = 0; i < nn; i++) total += (td[i] == 0) ? 1 : td[i];
    num_steps = 4'(n);
    loop_en   = 1'b0;
    clk_div   = 8'(div);
    start     = 1'b1;
    tick();
    start     = 1'b0;
    for (int c = 0; c < total; c++) begin
      s = 0;
      acc = (td[0] == 0) ? 1 : td[0];
      while (c >= acc) begin
        s++;
        acc += (td[s] == 0) ? 1 : td[s];
      end
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_idx"},  32'(step_idx), 32'(s));
      check({tag, "_dout"}, 32'(d_out), 32'(tv[s]));
      check({tag, "_tclk"}, 32'(tclk_out), 32'((c / (div + 1)) % 2));
      tick();
    end
    check({tag, "_end_busy"}, 32'(busy), 32'd0);
    check({tag, "_end_done"}, 32'(done), 32'd1);
    check({tag, "_end_tclk"}, 32'(tclk_out), 32'd0);
    check({tag, "_end_idx"},  32'(step_idx), 32'(nn - 1));
    check({tag, "_end_dout"}, 32'(d_out), 32'(tv[nn - 1]));
    tick();
    check({tag, "_post_done"}, 32'(done), 32'd0);
    check({tag, "_post_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin tv[i] = 0; td[i] = 0; end

    // Reset values.
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_idx",  32'(step_idx), 32'd0);
    check("rst_dout", 32'(d_out), 32'd0);
    check("rst_tclk", 32'(tclk_out), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single shot: 0x8,1x9,0x1,1x4,0x1,1x10 -> done 33 cycles after start.
    wr(0, 0, 8); wr(1, 1, 9); wr(2, 0, 1); wr(3, 1, 4); wr(4, 0, 1); wr(5, 1, 10);
    play_check("ss", 6, 4);

    // Reset during step 2, without a clock edge.
    num_steps = 4'd6; loop_en = 1'b0; clk_div = 8'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 17; c++) tick();
    check("mr_pre_idx",  32'(step_idx), 32'd2);
    check("mr_pre_tclk", 32'(tclk_out), 32'd1);
    check("mr_pre_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_done", 32'(done), 32'd0);
    check("mr_dout", 32'(d_out), 32'd0);
    check("mr_tclk", 32'(tclk_out), 32'd0);
    check("mr_idx",  32'(step_idx), 32'd0);
    #1 rst = 1'b0;
    tick();
    // Cleared table: 8 steps of value 0, one cycle each.
    for (int i = 0; i < 8; i++) begin tv[i] = 0; td[i] = 0; end
    play_check("clr", 8, 0);

    // Zero duration on entry 1 and num_steps clamped to DEPTH.
    for (int i = 0; i < 8; i++) wr(i, i % 2, (i == 1) ? 0 : 2);
    play_check("clamp", 9, 1);

    // Loop mode with ignored writes/starts and input changes during RUN.
    wr(0, 1, 3); wr(1, 0, 5);
    num_steps = 4'd2; loop_en = 1'b1; clk_div = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c <= 17; c++) begin
      check("lp_idx",  32'(step_idx), ((c % 8) < 3) ? 32'd0 : 32'd1);
      check("lp_dout", 32'(d_out),    ((c % 8) < 3) ? 32'd1 : 32'd0);
      check("lp_tclk", 32'(tclk_out), 32'((c / 3) % 2));
      check("lp_busy", 32'(busy), 32'd1);
      check("lp_done", 32'(done), 32'd0);
      if (c == 10) begin
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_value = 1'b0; cfg_dur = 8'd7;
        start = 1'b1; num_steps = 4'd1; loop_en = 1'b0; clk_div = 8'd0;
      end else begin
        cfg_we = 1'b0; start = 1'b0;
      end
      if (c < 17) tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("lp_stop_busy", 32'(busy), 32'd0);
    check("lp_stop_done", 32'(done), 32'd0);
    check("lp_stop_tclk", 32'(tclk_out), 32'd0);
    check("lp_stop_dout", 32'(d_out), 32'd1);
    check("lp_stop_idx",  32'(step_idx), 32'd0);
    tick();
    check("lp_post_done", 32'(done), 32'd0);
    check("lp_post_busy", 32'(busy), 32'd0);
    // Table must still hold (1,3),(0,5).
    play_check("tbl", 2, 0);

    // start with num_steps=0 is ignored.
    num_steps = 4'd0; start = 1'b1;
    tick();
    check("ns0_busy1", 32'(busy), 32'd0);
    tick();
    start = 1'b0;
    check("ns0_busy2", 32'(busy), 32'd0);
    check("ns0_done",  32'(done), 32'd0);

    // stop on the final cycle of the last step: no done.
    wr(0, 1, 2); wr(1, 0, 3);
    num_steps = 4'd2; loop_en = 1'b0; clk_div = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    check("sim_pre_idx",  32'(step_idx), 32'd1);
    check("sim_pre_busy", 32'(busy), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("sim_busy", 32'(busy), 32'd0);
    check("sim_done", 32'(done), 32'd0);
    check("sim_tclk", 32'(tclk_out), 32'd0);
    check("sim_dout", 32'(d_out), 32'd0);
    check("sim_idx",  32'(step_idx), 32'd1);
    tick();
    check("sim_post_done", 32'(done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
